// File: rtl/hp48_bus_ram.sv
// rtl/hp48_bus_ram.sv - HP48 nibble-bus memory responder with PC/DP pointers and a configurable window
module hp48_bus_ram #(
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        strobe,
    input  logic [3:0]  command,
    input  logic [19:0] address,
    input  logic [3:0]  nibble_in,
    output logic [3:0]  nibble_out,
    output logic        nibble_valid,
    output logic        configured,
    output logic        bus_error
);

    localparam logic [3:0] BUSCMD_NOP       = 4'h0;
    localparam logic [3:0] BUSCMD_PC_READ   = 4'h1;
    localparam logic [3:0] BUSCMD_DP_READ   = 4'h2;
    localparam logic [3:0] BUSCMD_DP_WRITE  = 4'h4;
    localparam logic [3:0] BUSCMD_LOAD_PC   = 4'h5;
    localparam logic [3:0] BUSCMD_LOAD_DP   = 4'h6;
    localparam logic [3:0] BUSCMD_CONFIGURE = 4'h7;
    localparam logic [3:0] BUSCMD_RESET     = 4'hF;

    localparam int RAM_DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        CFG_UNCONF = 2'd0,
        CFG_SIZED  = 2'd1,
        CFG_CONF   = 2'd2
    } cfg_e;

    cfg_e        cfg_q, cfg_d;
    logic [19:0] pc_ptr_q, pc_ptr_d;
    logic [19:0] dp_ptr_q, dp_ptr_d;
    logic [19:0] mask_q, mask_d;
    logic [19:0] base_q, base_d;
    logic [3:0]  nibble_out_q, nibble_out_d;
    logic        nibble_valid_q, nibble_valid_d;
    logic        bus_error_q, bus_error_d;

    logic [3:0]  mem_q [0:RAM_DEPTH-1];
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_waddr;
    logic [3:0]           mem_wdata;

    logic                 pc_hit;
    logic                 dp_hit;
    logic [ADDR_BITS-1:0] pc_off;
    logic [ADDR_BITS-1:0] dp_off;

    always_comb begin
        pc_hit = (cfg_q == CFG_CONF) && ((pc_ptr_q & mask_q) == base_q);
        dp_hit = (cfg_q == CFG_CONF) && ((dp_ptr_q & mask_q) == base_q);
        pc_off = pc_ptr_q[ADDR_BITS-1:0];
        dp_off = dp_ptr_q[ADDR_BITS-1:0];
    end

    // Pointers advance on every read/write even on a miss so that all
    // responders sharing the bus keep identical pointer values.
    always_comb begin
        cfg_d          = cfg_q;
        pc_ptr_d       = pc_ptr_q;
        dp_ptr_d       = dp_ptr_q;
        mask_d         = mask_q;
        base_d         = base_q;
        nibble_out_d   = nibble_out_q;
        nibble_valid_d = 1'b0;
        bus_error_d    = bus_error_q;
        mem_we         = 1'b0;
        mem_waddr      = dp_off;
        mem_wdata      = nibble_in;

        if (strobe) begin
            case (command)
                BUSCMD_NOP: begin
                end
                BUSCMD_LOAD_PC: pc_ptr_d = address;
                BUSCMD_LOAD_DP: dp_ptr_d = address;
                BUSCMD_PC_READ: begin
                    if (pc_hit) begin
                        nibble_out_d   = mem_q[pc_off];
                        nibble_valid_d = 1'b1;
                    end
                    pc_ptr_d = pc_ptr_q + 20'd1;
                end
                BUSCMD_DP_READ: begin
                    if (dp_hit) begin
                        nibble_out_d   = mem_q[dp_off];
                        nibble_valid_d = 1'b1;
                    end
                    dp_ptr_d = dp_ptr_q + 20'd1;
                end
                BUSCMD_DP_WRITE: begin
                    mem_we   = dp_hit;
                    dp_ptr_d = dp_ptr_q + 20'd1;
                end
                BUSCMD_CONFIGURE: begin
                    case (cfg_q)
                        CFG_UNCONF: begin
                            mask_d = address;
                            cfg_d  = CFG_SIZED;
                        end
                        CFG_SIZED: begin
                            base_d = address & mask_q;
                            cfg_d  = CFG_CONF;
                        end
                        default: begin
                        end
                    endcase
                end
                BUSCMD_RESET: begin
                    cfg_d  = CFG_UNCONF;
                    mask_d = 20'd0;
                    base_d = 20'd0;
                end
                default: bus_error_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q          <= CFG_UNCONF;
            pc_ptr_q       <= 20'd0;
            dp_ptr_q       <= 20'd0;
            mask_q         <= 20'd0;
            base_q         <= 20'd0;
            nibble_out_q   <= 4'd0;
            nibble_valid_q <= 1'b0;
            bus_error_q    <= 1'b0;
        end else begin
            cfg_q          <= cfg_d;
            pc_ptr_q       <= pc_ptr_d;
            dp_ptr_q       <= dp_ptr_d;
            mask_q         <= mask_d;
            base_q         <= base_d;
            nibble_out_q   <= nibble_out_d;
            nibble_valid_q <= nibble_valid_d;
            bus_error_q    <= bus_error_d;
        end
    end

    // RAM contents survive reset; a write strobed together with reset is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign nibble_out   = nibble_out_q;
    assign nibble_valid = nibble_valid_q;
    assign configured   = (cfg_q == CFG_CONF);
    assign bus_error    = bus_error_q;

endmodule

// File: tb/tb_hp48_bus_ram.sv
// tb/tb_hp48_bus_ram.sv - self-checking bench for hp48_bus_ram against a behavioural bus model
module tb_hp48_bus_ram;

    localparam logic [3:0] C_NOP   = 4'h0;
    localparam logic [3:0] C_PCRD  = 4'h1;
    localparam logic [3:0] C_DPRD  = 4'h2;
    localparam logic [3:0] C_DPWR  = 4'h4;
    localparam logic [3:0] C_LDPC  = 4'h5;
    localparam logic [3:0] C_LDDP  = 4'h6;
    localparam logic [3:0] C_CONF  = 4'h7;
    localparam logic [3:0] C_RST   = 4'hF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        strobe = 1'b0;
    logic [3:0]  command = 4'h0;
    logic [19:0] address = 20'h0;
    logic [3:0]  nibble_in = 4'h0;
    logic [3:0]  nibble_out;
    logic        nibble_valid;
    logic        configured;
    logic        bus_error;

    int compared = 0;
    int mismatched = 0;

    // Reference model state
    logic [19:0] m_pc, m_dp, m_mask, m_base;
    int          m_cfg;
    logic [3:0]  m_ram [256];
    bit          m_known [256];
    logic [3:0]  m_out;
    bit          m_out_known;
    logic        m_valid, m_err;

    hp48_bus_ram #(.ADDR_BITS(8)) dut (
        .clk(clk), .reset(reset), .strobe(strobe), .command(command),
        .address(address), .nibble_in(nibble_in), .nibble_out(nibble_out),
        .nibble_valid(nibble_valid), .configured(configured), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_hit(input logic [19:0] p);
        return (m_cfg == 2) && ((p & m_mask) == m_base);
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, {19'd0, nibble_valid}, {19'd0, m_valid});
        check({tag, ".configured"}, {19'd0, configured}, {19'd0, (m_cfg == 2)});
        check({tag, ".bus_error"}, {19'd0, bus_error}, {19'd0, m_err});
        if (m_out_known) check({tag, ".nibble_out"}, {16'd0, nibble_out}, {16'd0, m_out});
    endtask

    task automatic model_reset();
        m_cfg = 0; m_mask = 0; m_base = 0; m_pc = 0; m_dp = 0;
        m_out = 0; m_out_known = 1; m_valid = 0; m_err = 0;
    endtask

    task automatic model_cmd(input logic [3:0] cmd, input logic [19:0] addr, input logic [3:0] nib);
        m_valid = 0;
        case (cmd)
            C_NOP: ;
            C_LDPC: m_pc = addr;
            C_LDDP: m_dp = addr;
            C_PCRD: begin
                if (m_hit(m_pc)) begin
                    m_out = m_ram[m_pc[7:0]]; m_out_known = m_known[m_pc[7:0]]; m_valid = 1;
                end
                m_pc = m_pc + 20'd1;
            end
            C_DPRD: begin
                if (m_hit(m_dp)) begin
                    m_out = m_ram[m_dp[7:0]]; m_out_known = m_known[m_dp[7:0]]; m_valid = 1;
                end
                m_dp = m_dp + 20'd1;
            end
            C_DPWR: begin
                if (m_hit(m_dp)) begin
                    m_ram[m_dp[7:0]] = nib; m_known[m_dp[7:0]] = 1;
                end
                m_dp = m_dp + 20'd1;
            end
            C_CONF: begin
                if (m_cfg == 0) begin m_mask = addr; m_cfg = 1; end
                else if (m_cfg == 1) begin m_base = addr & m_mask; m_cfg = 2; end
            end
            C_RST: begin m_cfg = 0; m_mask = 0; m_base = 0; end
            default: m_err = 1;
        endcase
    endtask

    // Called at a negedge; returns at the following negedge with strobe low,
    // so consecutive calls produce back-to-back strobes.
    task automatic cmd(input string tag, input logic [3:0] c, input logic [19:0] a, input logic [3:0] n);
        strobe = 1; command = c; address = a; nibble_in = n;
        @(posedge clk);
        model_cmd(c, a, n);
        #1;
        check_outputs(tag);
        @(negedge clk);
        strobe = 0;
    endtask

    task automatic idle(input string tag);
        strobe = 0;
        @(posedge clk);
        m_valid = 0;
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag, input bit with_strobe, input logic [3:0] c, input logic [19:0] a);
        reset = 1; strobe = with_strobe; command = c; address = a; nibble_in = 4'hE;
        @(posedge clk);
        model_reset();
        #1;
        check_outputs(tag);
        @(negedge clk);
        reset = 0; strobe = 0;
    endtask

    task automatic configure(input logic [19:0] sz, input logic [19:0] bs);
        cmd("cfg_size", C_CONF, sz, 4'h0);
        cmd("cfg_base", C_CONF, bs, 4'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin m_ram[i] = 4'h0; m_known[i] = 0; end
        model_reset();
        @(negedge clk);

        // Reset state
        do_reset("reset0", 0, C_NOP, 20'h0);
        check("reset0.pc", dut.pc_ptr_q, 20'h0);
        check("reset0.dp", dut.dp_ptr_q, 20'h0);
        check("reset0.out", {16'd0, nibble_out}, 20'h0);

        // Unconfigured: write dropped, read misses
        cmd("unc_lddp", C_LDDP, 20'h00000, 4'h0);
        cmd("unc_wr", C_DPWR, 20'h0, 4'h3);
        cmd("unc_lddp2", C_LDDP, 20'h00000, 4'h0);
        cmd("unc_rd", C_DPRD, 20'h0, 4'h0);
        cmd("one_cfg", C_CONF, 20'hFFF00, 4'h0);
        check("one_cfg.configured", {19'd0, configured}, 20'h0);

        // Reset between CONFIGURE steps restarts the size step
        do_reset("mid_cfg_reset", 0, C_NOP, 20'h0);
        cmd("re_size", C_CONF, 20'hFFF00, 4'h0);
        check("re_size.configured", {19'd0, configured}, 20'h0);
        cmd("re_base", C_CONF, 20'h80000, 4'h0);
        check("re_base.configured", {19'd0, configured}, 20'h1);
        cmd("third_cfg", C_CONF, 20'h12345, 4'h0);
        check("third_cfg.base", dut.base_q, 20'h80000);

        // Configure and read back
        cmd("lddp", C_LDDP, 20'h80010, 4'h0);
        cmd("wr_a", C_DPWR, 20'h0, 4'hA);
        cmd("wr_5", C_DPWR, 20'h0, 4'h5);
        cmd("ldpc", C_LDPC, 20'h80010, 4'h0);
        cmd("rd_a", C_PCRD, 20'h0, 4'h0);
        check("rd_a.data", {16'd0, nibble_out}, 20'hA);
        cmd("rd_5", C_PCRD, 20'h0, 4'h0);
        check("rd_5.data", {16'd0, nibble_out}, 20'h5);
        idle("valid_pulse");
        check("pc_after_reads", dut.pc_ptr_q, 20'h80012);

        // Miss
        cmd("miss_ldpc", C_LDPC, 20'h70000, 4'h0);
        cmd("miss_rd", C_PCRD, 20'h0, 4'h0);
        check("miss.pc", dut.pc_ptr_q, 20'h70001);
        cmd("miss_lddp", C_LDDP, 20'h70000, 4'h0);
        cmd("miss_wr", C_DPWR, 20'h0, 4'hC);
        cmd("miss_ldpc2", C_LDPC, 20'h80000, 4'h0);
        cmd("miss_rdback", C_PCRD, 20'h0, 4'h0);

        // RESET command
        cmd("rstcmd", C_RST, 20'h0, 4'h0);
        cmd("rst_ldpc", C_LDPC, 20'h80010, 4'h0);
        cmd("rst_rd", C_PCRD, 20'h0, 4'h0);

        // Whole-space window, wrap with back-to-back writes
        configure(20'h00000, 20'h00000);
        cmd("wrap_lddp", C_LDDP, 20'hFFFFF, 4'h0);
        cmd("wrap_w7", C_DPWR, 20'h0, 4'h7);
        cmd("wrap_w9", C_DPWR, 20'h0, 4'h9);
        check("wrap.dp", dut.dp_ptr_q, 20'h00001);
        cmd("wrap_ldpc", C_LDPC, 20'hFFFFF, 4'h0);
        cmd("wrap_r7", C_PCRD, 20'h0, 4'h0);
        check("wrap_r7.data", {16'd0, nibble_out}, 20'h7);
        cmd("wrap_r9", C_PCRD, 20'h0, 4'h0);
        check("wrap_r9.data", {16'd0, nibble_out}, 20'h9);

        // Write then read in the very next cycle
        cmd("b2b_lddp", C_LDDP, 20'h00042, 4'h0);
        cmd("b2b_ldpc", C_LDPC, 20'h00042, 4'h0);
        cmd("b2b_wr", C_DPWR, 20'h0, 4'hB);
        cmd("b2b_rd", C_PCRD, 20'h0, 4'h0);
        check("b2b_rd.data", {16'd0, nibble_out}, 20'hB);

        // Error stickiness
        cmd("bad_cmd", 4'h9, 20'h0, 4'h0);
        check("bad_cmd.err", {19'd0, bus_error}, 20'h1);
        cmd("after_bad", C_LDPC, 20'h00001, 4'h0);
        check("after_bad.err", {19'd0, bus_error}, 20'h1);

        // Reset with simultaneous strobe: reset wins
        do_reset("reset_strobe", 1, C_LDPC, 20'h12345);
        check("reset_strobe.pc", dut.pc_ptr_q, 20'h0);

        // Randomized phase
        configure(20'hFFF00, {12'($urandom_range(0, 4095)), 8'h00});
        for (int i = 0; i < 400; i++) begin
            int sel;
            logic [19:0] a;
            logic [3:0] c;
            sel = $urandom_range(0, 99);
            a = $urandom_range(0, 1) ? (m_base | 20'($urandom_range(0, 255))) : 20'($urandom);
            if (sel < 12) c = C_LDPC;
            else if (sel < 24) c = C_LDDP;
            else if (sel < 44) c = C_PCRD;
            else if (sel < 62) c = C_DPRD;
            else if (sel < 86) c = C_DPWR;
            else if (sel < 90) c = C_NOP;
            else if (sel < 93) c = C_CONF;
            else if (sel < 95) c = C_RST;
            else if (sel < 96) c = 4'(($urandom_range(0, 1) == 0) ? 3 : $urandom_range(8, 14));
            else c = C_NOP;
            if (sel >= 96) idle("rnd_idle");
            else cmd("rnd", c, a, 4'($urandom));
            if (m_cfg != 2 && $urandom_range(0, 3) == 0) configure(20'hFFF00, m_base);
            if (m_err && $urandom_range(0, 15) == 0) begin
                do_reset("rnd_reset", 0, C_NOP, 20'h0);
                configure(20'hFFF00, {12'($urandom_range(0, 4095)), 8'h00});
            end
            check("rnd.pc", dut.pc_ptr_q, m_pc);
            check("rnd.dp", dut.dp_ptr_q, m_dp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
